gray_stream_ctrl: RTL and testbench



---
 rtl/gray_ctrl_pkg.sv | 20 ++
 rtl/gray_out_fifo.sv | 63 ++++++
 rtl/gray_stream_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gray_stream_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ctrl_pkg.sv
// Shared types for the gray stream controller:
// FSM state, output FIFO entry, default core latency.
package gray_ctrl_pkg;

   localparam int DEF_LATENCY = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   typedef struct packed {
      logic [7:0] gray;
      logic       sof;
      logic       eol;
   } fifo_entry_t;

endpackage

// File: rtl/gray_out_fifo.sv
// Show-ahead output FIFO for gray results with sof/eol tags.
// Write and pop may coincide at any fill level, including full.
module gray_out_fifo
   import gray_ctrl_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_i,
   input  fifo_entry_t                wr_data_i,
   input  logic                       rd_i,
   output fifo_entry_t                rd_data_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wp_q;
   logic [AW-1:0] rp_q;
   logic [CW-1:0] cnt_q;
   logic          do_rd;
   logic          full;

   assign empty_o   = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign do_rd     = rd_i && !empty_o;
   assign rd_data_o = mem_q[rp_q];
   assign count_o   = cnt_q;

   // storage, pointers and fill count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr_i) begin
            mem_q[wp_q] <= wr_data_i;
            wp_q        <= wp_q + AW'(1);
         end
         if (do_rd) begin
            rp_q <= rp_q + AW'(1);
         end
         if (wr_i && !do_rd) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (!wr_i && do_rd) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   a_no_overflow : assert property (
      @(posedge clk) disable iff (rst) !(wr_i && full && !do_rd)
   );

endmodule

// File: rtl/gray_stream_ctrl.sv
// Frame sequencer around a fixed-latency RGB2GRAY core.
// Credits cover FIFO fill plus core in-flight results.
module gray_stream_ctrl
   import gray_ctrl_pkg::*;
#(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int LATENCY    = DEF_LATENCY,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [23:0] s_rgb,
   output logic [23:0] core_rgb,
   input  logic [7:0]  core_gray,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_gray,
   output logic        m_sof,
   output logic        m_eol
);

   localparam int NPIX = WIDTH * HEIGHT;
   localparam int PW   = $clog2(NPIX + 1);
   localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam int OW   = $clog2(FIFO_DEPTH + LATENCY + 1);

   state_e            state_q;
   state_e            state_d;
   logic [PW-1:0]     in_cnt_q;
   logic [PW-1:0]     in_cnt_d;
   logic [PW-1:0]     out_cnt_q;
   logic [PW-1:0]     out_cnt_d;
   logic [XW-1:0]     col_q;
   logic [XW-1:0]     col_d;
   logic [LATENCY-1:0] v_q;
   logic [LATENCY-1:0] sof_q;
   logic [LATENCY-1:0] eol_q;
   logic              accept;
   logic              pop;
   logic              last_in;
   logic              last_out;
   logic              empty;
   logic [CW-1:0]     fcount;
   logic [OW-1:0]     inflight;
   logic [OW-1:0]     outstanding;
   fifo_entry_t       wr_data;
   fifo_entry_t       head;

   assign accept   = s_valid && s_ready;
   assign pop      = m_valid && m_ready;
   assign last_in  = (in_cnt_q == PW'(NPIX - 1));
   assign last_out = (out_cnt_q == PW'(NPIX - 1));
   assign core_rgb = accept ? s_rgb : 24'd0;

   assign wr_data.gray = core_gray;
   assign wr_data.sof  = sof_q[LATENCY-1];
   assign wr_data.eol  = eol_q[LATENCY-1];

   assign m_valid = !empty;
   assign m_gray  = head.gray;
   assign m_sof   = head.sof;
   assign m_eol   = head.eol;

   // results still inside the core pipeline
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + OW'(v_q[i]);
      end
      outstanding = OW'(fcount) + inflight;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && last_in) state_d = DRAIN;
         DRAIN:   if (pop && last_out) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and credit-based admission
   always_comb begin
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      s_ready = (state_q == RUN) && (outstanding < OW'(FIFO_DEPTH));
   end

   // pixel counters and column position
   always_comb begin
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      col_d     = col_q;
      if (state_q == IDLE && start) begin
         in_cnt_d  = '0;
         out_cnt_d = '0;
         col_d     = '0;
      end else begin
         if (accept) begin
            in_cnt_d = in_cnt_q + PW'(1);
            col_d    = (col_q == XW'(WIDTH - 1)) ? '0 : col_q + XW'(1);
         end
         if (pop) begin
            out_cnt_d = out_cnt_q + PW'(1);
         end
      end
   end

   // counters plus valid/tag shift register tracking the core
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         col_q     <= '0;
         v_q       <= '0;
         sof_q     <= '0;
         eol_q     <= '0;
      end else begin
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         col_q     <= col_d;
         v_q[0]    <= accept;
         sof_q[0]  <= (in_cnt_q == '0);
         eol_q[0]  <= (col_q == XW'(WIDTH - 1));
         for (int i = 1; i < LATENCY; i++) begin
            v_q[i]   <= v_q[i-1];
            sof_q[i] <= sof_q[i-1];
            eol_q[i] <= eol_q[i-1];
         end
      end
   end

   gray_out_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (v_q[LATENCY-1]),
      .wr_data_i (wr_data),
      .rd_i      (pop),
      .rd_data_o (head),
      .empty_o   (empty),
      .count_o   (fcount)
   );

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Bench for gray_stream_ctrl: two instances (2x2 and 3x3, depth 4)
// each driven into a behavioural RGB2GRAY core model.
module tb_gray_stream_ctrl;

   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start   [2];
   logic        s_valid [2];
   logic        m_ready [2];
   logic [23:0] s_rgb   [2];
   logic        busy    [2];
   logic        done    [2];
   logic        s_ready [2];
   logic        m_valid [2];
   logic        m_sof   [2];
   logic        m_eol   [2];
   logic [23:0] core_rgb  [2];
   logic [7:0]  core_gray [2];
   logic [7:0]  m_gray    [2];
   logic [7:0]  cpipe [2][LAT];

   gray_stream_ctrl #(
      .WIDTH(2), .HEIGHT(2), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
   ) u_a (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]),
      .done(done[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
      .s_rgb(s_rgb[0]), .core_rgb(core_rgb[0]),
      .core_gray(core_gray[0]), .m_valid(m_valid[0]),
      .m_ready(m_ready[0]), .m_gray(m_gray[0]), .m_sof(m_sof[0]),
      .m_eol(m_eol[0])
   );

   gray_stream_ctrl #(
      .WIDTH(3), .HEIGHT(3), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
   ) u_b (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]),
      .done(done[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
      .s_rgb(s_rgb[1]), .core_rgb(core_rgb[1]),
      .core_gray(core_gray[1]), .m_valid(m_valid[1]),
      .m_ready(m_ready[1]), .m_gray(m_gray[1]), .m_sof(m_sof[1]),
      .m_eol(m_eol[1])
   );

   function automatic logic [7:0] gray_of(logic [23:0] p);
      int s;
      s = 76 * int'(p[23:16]) + 149 * int'(p[15:8]) + 29 * int'(p[7:0]);
      return 8'(s >> 8);
   endfunction

   function automatic int wof(int i);
      return (i == 0) ? 2 : 3;
   endfunction

   // RGB2GRAY core: LAT register stages, no reset
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         cpipe[i][0] <= gray_of(core_rgb[i]);
         for (int j = 1; j < LAT; j++) cpipe[i][j] <= cpipe[i][j-1];
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) core_gray[i] = cpipe[i][LAT-1];
   end

   int n_cmp = 0;
   int n_bad = 0;
   int ec = 0;

   bit          act  [2];
   int          acc  [2];
   int          pops [2];
   int          hd   [2];
   int          tl   [2];
   int          q_t   [2][64];
   int          q_idx [2][64];
   logic [23:0] q_rgb [2][64];
   logic        mv_prev [2];
   int          n_out [2];
   int          n_sof [2];
   int          n_eol [2];
   int          a_cyc [2];

   task automatic chk(string nm, int i, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s[%0d] cycle %0d: got %0h want %0h",
                  nm, i, ec, got, want);
      end
   endtask

   // reference model and per-cycle compare
   initial begin
      int n, h, w;
      bit sr_e, mv_e, dn_e, acc_now, pop_now;
      logic [23:0] crgb_e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            w = wof(i);
            n = w * w;
            if (rst) begin
               chk("rst_busy", i, int'(busy[i]), 0);
               chk("rst_done", i, int'(done[i]), 0);
               chk("rst_s_ready", i, int'(s_ready[i]), 0);
               chk("rst_m_valid", i, int'(m_valid[i]), 0);
               chk("rst_m_gray", i, int'(m_gray[i]), 0);
               chk("rst_m_sof", i, int'(m_sof[i]), 0);
               chk("rst_m_eol", i, int'(m_eol[i]), 0);
               chk("rst_core_rgb", i, int'(core_rgb[i]), 0);
               act[i] = 0; acc[i] = 0; pops[i] = 0;
               hd[i] = 0; tl[i] = 0; mv_prev[i] = 0;
               a_cyc[i] = 0;
            end else begin
               h = hd[i] & 63;
               sr_e = act[i] && acc[i] < n && (acc[i] - pops[i]) < DEPTH;
               mv_e = (hd[i] != tl[i]) && (ec >= q_t[i][h] + LAT);
               dn_e = act[i] && pops[i] == n;
               acc_now = s_valid[i] && sr_e;
               crgb_e = acc_now ? s_rgb[i] : 24'd0;
               chk("busy", i, int'(busy[i]), int'(act[i]));
               chk("done", i, int'(done[i]), int'(dn_e));
               chk("s_ready", i, int'(s_ready[i]), int'(sr_e));
               chk("m_valid", i, int'(m_valid[i]), int'(mv_e));
               chk("core_rgb", i, int'(core_rgb[i]), int'(crgb_e));
               if (mv_e) begin
                  chk("m_gray", i, int'(m_gray[i]),
                      int'(gray_of(q_rgb[i][h])));
                  chk("m_sof", i, int'(m_sof[i]), int'(q_idx[i][h] == 0));
                  chk("m_eol", i, int'(m_eol[i]),
                      int'(q_idx[i][h] % w == w - 1));
                  if (q_rgb[i][h] == 24'hFFFFFF)
                     chk("white_gray", i, int'(m_gray[i]), 8'hFD);
               end
               if (m_valid[i] && !mv_prev[i] && hd[i] != tl[i])
                  chk("latency", i, ec - q_t[i][h], 3);
               mv_prev[i] = m_valid[i];
               if (dn_e && i == 0) begin
                  chk("frame_outs", i, n_out[i], 4);
                  chk("frame_sofs", i, n_sof[i], 1);
                  chk("frame_eols", i, n_eol[i], 2);
               end
               if (dn_e && i == 1) begin
                  chk("frame_outs", i, n_out[i], 9);
                  chk("frame_sofs", i, n_sof[i], 1);
                  chk("frame_eols", i, n_eol[i], 3);
               end
               pop_now = mv_e && m_ready[i];
               if (acc_now) begin
                  q_t[i][tl[i] & 63]   = ec + 1;
                  q_rgb[i][tl[i] & 63] = s_rgb[i];
                  q_idx[i][tl[i] & 63] = acc[i];
                  tl[i]++;
                  acc[i]++;
               end
               if (pop_now) begin
                  hd[i]++;
                  pops[i]++;
                  n_out[i]++;
                  if (m_sof[i]) n_sof[i]++;
                  if (m_eol[i]) n_eol[i]++;
               end
               if (dn_e) begin
                  act[i] = 0;
               end else if (!act[i] && start[i]) begin
                  act[i] = 1; acc[i] = 0; pops[i] = 0;
                  n_out[i] = 0; n_sof[i] = 0; n_eol[i] = 0;
                  a_cyc[i] = 0;
               end
               if (act[i]) a_cyc[i]++;
               if (a_cyc[i] == 300)
                  chk("frame_timeout", i, int'(busy[i]), 0);
            end
         end
         ec++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic send(int i, logic [23:0] rgb);
      s_rgb[i]   = rgb;
      s_valid[i] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (s_ready[i]) break;
         tick();
      end
      tick();
      s_valid[i] = 1'b0;
   endtask

   task automatic wait_done(int i, int budget);
      for (int c = 0; c < budget; c++) begin
         if (done[i]) break;
         tick();
      end
      tick();
   endtask

   // directed stimulus
   initial begin
      for (int i = 0; i < 2; i++) begin
         start[i] = 0; s_valid[i] = 0; m_ready[i] = 1; s_rgb[i] = 0;
      end
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // white frame, full throughput
      s_rgb[0] = 24'hFFFFFF;
      s_valid[0] = 1'b1;
      pulse_start(0);
      wait_done(0, 100);
      s_valid[0] = 1'b0;
      repeat (2) tick();

      // single black pixel with an empty FIFO, then the rest
      pulse_start(0);
      send(0, 24'h000000);
      repeat (6) tick();
      send(0, 24'h123456);
      send(0, 24'hABCDEF);
      send(0, 24'h808080);
      wait_done(0, 100);
      repeat (2) tick();

      // start pulsed mid-frame
      pulse_start(0);
      send(0, 24'h0F1E2D);
      pulse_start(0);
      send(0, 24'hFF0000);
      pulse_start(0);
      send(0, 24'h00FF00);
      send(0, 24'h0000FF);
      wait_done(0, 100);
      repeat (2) tick();

      // reset after two accepts, then a clean frame
      m_ready[0] = 1'b0;
      pulse_start(0);
      send(0, 24'h111111);
      send(0, 24'h222222);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      m_ready[0] = 1'b1;
      tick();
      pulse_start(0);
      send(0, 24'hFFFFFF);
      send(0, 24'h3C5A78);
      send(0, 24'hC0FFEE);
      send(0, 24'h010203);
      wait_done(0, 100);
      repeat (2) tick();

      // backpressure on the 3x3 instance
      m_ready[1] = 1'b0;
      s_valid[1] = 1'b1;
      s_rgb[1] = 24'($urandom);
      pulse_start(1);
      repeat (20) begin
         s_rgb[1] = 24'($urandom);
         tick();
      end
      m_ready[1] = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (done[1]) break;
         s_rgb[1] = 24'($urandom);
         tick();
      end
      s_valid[1] = 1'b0;
      repeat (2) tick();

      // full FIFO with m_ready toggling every cycle
      m_ready[1] = 1'b0;
      s_valid[1] = 1'b1;
      pulse_start(1);
      repeat (10) begin
         s_rgb[1] = 24'($urandom);
         tick();
      end
      for (int c = 0; c < 200; c++) begin
         if (done[1]) break;
         m_ready[1] = ~m_ready[1];
         s_rgb[1] = 24'($urandom);
         tick();
      end
      s_valid[1] = 1'b0;
      m_ready[1] = 1'b1;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
